serial_char_tx: RTL and testbench

//  Parallel-to-serial character transmitter feeding the inter-board network link.

---
 rtl/serial_char_tx.sv | 161 ++++++++++++++++
 tb/tb_serial_char_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_char_tx.sv
// Async-serial character transmitter with a one-entry holding register.
// The frame is a start bit, LSB-first data, optional parity, then one or two stop bits.
module serial_char_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       transmit_enable,
  output logic       tx_out,
  output logic       char_sent,
  output logic       busy,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shifter, shifter_nxt;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 parity_bit, parity_nxt;
  logic                 hold_full;
  logic                 bit_end;
  logic                 transfer;
  logic                 frame_done;
  logic                 load_ok;
  logic                 tx_nxt;

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shifter_nxt = shifter;
    parity_nxt  = parity_bit;
    transfer    = 1'b0;
    frame_done  = 1'b0;
    bit_end     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    if (state != IDLE)
      clk_cnt_nxt = bit_end ? '0 : clk_cnt + CNT_W'(1);

    unique case (state)
      IDLE: begin
        if (hold_full && transmit_enable)
          transfer = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            shifter_nxt = shifter >> 1;
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            // A waiting byte goes straight into a new start bit with no idle cycle.
            if (hold_full && transmit_enable) begin
              transfer = 1'b1;
            end else begin
              state_nxt  = IDLE;
              frame_done = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (transfer) begin
      state_nxt   = START;
      shifter_nxt = hold_reg;
      parity_nxt  = (^hold_reg) ^ 1'(PARITY_ODD);
      clk_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end

    // The line level is computed from the next state so tx_out can be a plain flop.
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shifter_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase

    load_ok = load && (!hold_full || transfer);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shifter    <= shifter_nxt;
      parity_bit <= parity_nxt;
      tx_out     <= tx_nxt;
    end
  end

  // A load on the same edge the holding register drains is accepted, and clearing char_sent beats setting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      char_sent <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_ok) begin
        hold_reg  <= data_in[DATA_BITS-1:0];
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end

      if (load && !load_ok)
        overrun <= 1'b1;

      if (load_ok)
        char_sent <= 1'b0;
      else if (frame_done && !hold_full)
        char_sent <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_char_tx.sv
// Directed and random frames on three transmitter configurations (8N1, 8E1, 8O2) at 4 clocks per bit.
// Every line sample is compared against a frame built from the byte with plain arithmetic.
module tb_serial_char_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_v     [3];
  logic [7:0] data_v      [3];
  logic       load_v      [3];
  logic       en_v        [3];
  logic       tx_v        [3];
  logic       char_sent_v [3];
  logic       busy_v      [3];
  logic       overrun_v   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_char_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset_v[0]), .data_in(data_v[0]), .load(load_v[0]),
    .transmit_enable(en_v[0]), .tx_out(tx_v[0]), .char_sent(char_sent_v[0]),
    .busy(busy_v[0]), .overrun(overrun_v[0]));

  serial_char_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset_v[1]), .data_in(data_v[1]), .load(load_v[1]),
    .transmit_enable(en_v[1]), .tx_out(tx_v[1]), .char_sent(char_sent_v[1]),
    .busy(busy_v[1]), .overrun(overrun_v[1]));

  serial_char_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset_v[2]), .data_in(data_v[2]), .load(load_v[2]),
    .transmit_enable(en_v[2]), .tx_out(tx_v[2]), .char_sent(char_sent_v[2]),
    .busy(busy_v[2]), .overrun(overrun_v[2]));

  function automatic int pe_of(int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int stop_of(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic logic odd_of(int i);
    return (i == 2);
  endfunction

  function automatic int frame_bits(int i);
    return 1 + 8 + pe_of(i) + stop_of(i);
  endfunction

  // Bit number idx of the frame carrying byte b on instance i.
  function automatic logic exp_bit(int i, logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (pe_of(i) == 1 && idx == 9) return (^b) ^ odd_of(i);
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Loads byte b and advances to just after the edge that starts its frame.
  task automatic applyStimulus(input int i, input logic [7:0] b);
    data_v[i] = b;
    load_v[i] = 1'b1;
    step();
    load_v[i] = 1'b0;
    step();
  endtask

  // end_mode: 0 idle with char_sent=1, 1 back-to-back start, 2 idle with char_sent=0.
  task automatic frame_check(input int i, input logic [7:0] b,
                             input int la, input logic [7:0] lb,
                             input int lc, input logic [7:0] lcb,
                             input int drop_at, input int end_mode);
    int nclk;
    nclk = frame_bits(i) * CPB;
    for (int k = 0; k < nclk; k++) begin
      checkOutput($sformatf("i%0d_b%02h_tx_bit%0d_clk%0d", i, b, k / CPB, k),
                  tx_v[i], exp_bit(i, b, k / CPB));
      if (k == 0) checkOutput($sformatf("i%0d_busy_start", i), busy_v[i], 1'b1);
      if (k == nclk - 1) checkOutput($sformatf("i%0d_char_sent_last_clk", i), char_sent_v[i], 1'b0);
      if (k == lc) checkOutput($sformatf("i%0d_overrun_before", i), overrun_v[i], 1'b0);
      load_v[i] = 1'b0;
      if (k == la) begin
        data_v[i] = lb;
        load_v[i] = 1'b1;
      end
      if (k == lc) begin
        data_v[i] = lcb;
        load_v[i] = 1'b1;
      end
      if (k == drop_at) en_v[i] = 1'b0;
      step();
    end
    load_v[i] = 1'b0;
    if (end_mode == 1) begin
      checkOutput($sformatf("i%0d_b2b_tx", i), tx_v[i], 1'b0);
      checkOutput($sformatf("i%0d_b2b_busy", i), busy_v[i], 1'b1);
      checkOutput($sformatf("i%0d_b2b_char_sent", i), char_sent_v[i], 1'b0);
    end else begin
      checkOutput($sformatf("i%0d_end_tx", i), tx_v[i], 1'b1);
      checkOutput($sformatf("i%0d_end_busy", i), busy_v[i], 1'b0);
      checkOutput($sformatf("i%0d_end_char_sent", i), char_sent_v[i], (end_mode == 0));
    end
  endtask

  task automatic check_idle(input int i, input int cycles, input string tag);
    for (int n = 0; n < cycles; n++) begin
      checkOutput($sformatf("%s_tx_%0d", tag, n), tx_v[i], 1'b1);
      checkOutput($sformatf("%s_busy_%0d", tag, n), busy_v[i], 1'b0);
      step();
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rb2;
    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b1;
      data_v[i]  = 8'h00;
      load_v[i]  = 1'b0;
      en_v[i]    = 1'b1;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("i%0d_rst_tx", i), tx_v[i], 1'b1);
      checkOutput($sformatf("i%0d_rst_char_sent", i), char_sent_v[i], 1'b0);
      checkOutput($sformatf("i%0d_rst_busy", i), busy_v[i], 1'b0);
      checkOutput($sformatf("i%0d_rst_overrun", i), overrun_v[i], 1'b0);
      reset_v[i] = 1'b0;
    end
    step();

    $display("[TB] basic 8N1 frame of A5");
    applyStimulus(0, 8'hA5);
    frame_check(0, 8'hA5, -1, 8'h00, -1, 8'h00, -1, 0);

    $display("[TB] parity frames of 07");
    applyStimulus(1, 8'h07);
    frame_check(1, 8'h07, -1, 8'h00, -1, 8'h00, -1, 0);
    applyStimulus(2, 8'h07);
    frame_check(2, 8'h07, -1, 8'h00, -1, 8'h00, -1, 0);

    $display("[TB] back-to-back frames and overrun");
    applyStimulus(0, 8'h11);
    frame_check(0, 8'h11, 5, 8'h22, 12, 8'h33, -1, 1);
    checkOutput("i0_overrun_set", overrun_v[0], 1'b1);
    frame_check(0, 8'h22, -1, 8'h00, -1, 8'h00, -1, 0);
    check_idle(0, 6, "i0_after_b2b");

    $display("[TB] load while disabled");
    en_v[0]   = 1'b0;
    data_v[0] = 8'h3C;
    load_v[0] = 1'b1;
    step();
    load_v[0] = 1'b0;
    checkOutput("i0_dis_char_sent", char_sent_v[0], 1'b0);
    check_idle(0, 6, "i0_disabled");
    en_v[0] = 1'b1;
    step();
    frame_check(0, 8'h3C, -1, 8'h00, -1, 8'h00, -1, 0);

    $display("[TB] enable dropped mid-frame");
    rb  = 8'($urandom);
    rb2 = 8'($urandom);
    applyStimulus(0, rb);
    frame_check(0, rb, 3, rb2, -1, 8'h00, 10, 2);
    check_idle(0, 8, "i0_held");
    en_v[0] = 1'b1;
    step();
    frame_check(0, rb2, -1, 8'h00, -1, 8'h00, -1, 0);

    $display("[TB] reset in data state");
    applyStimulus(0, 8'h5A);
    for (int k = 0; k < 10; k++) step();
    reset_v[0] = 1'b1;
    step();
    checkOutput("i0_midrst_tx", tx_v[0], 1'b1);
    checkOutput("i0_midrst_busy", busy_v[0], 1'b0);
    checkOutput("i0_midrst_char_sent", char_sent_v[0], 1'b0);
    checkOutput("i0_midrst_overrun", overrun_v[0], 1'b0);
    reset_v[0] = 1'b0;
    step();
    check_idle(0, 3, "i0_postrst");

    $display("[TB] random frames");
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 3; i++) begin
        rb = 8'($urandom);
        applyStimulus(i, rb);
        frame_check(i, rb, -1, 8'h00, -1, 8'h00, -1, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
